// File: rtl/conv_pkg.sv
// Shared FSM state type and output-geometry helpers for the convolution address sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of window positions along one axis; trailing pixels that cannot fill a window are dropped.
    function automatic int out_dim(input int img, input int ker, input int stride);
        if (stride < 1 || ker > img) begin
            return 1;
        end
        return (img - ker) / stride + 1;
    endfunction

    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/conv_wrap_counter.sv
// Modulo-LIMIT up counter: steps on en_i, flags its final value and pulses wrap_o on the stepping edge out of it.
module conv_wrap_counter
    import conv_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o,
    output logic wrap_o
);
    localparam int W = cnt_w(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(LIMIT - 1));
    assign wrap_o = en_i && last_o;

endmodule

// File: rtl/conv_addr_sequencer.sv
// Streams (image, kernel, output) address triples for one sliding-window convolution pass.
// First beat is live the cycle after start; every output is registered and holds while ready is low.
module conv_addr_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int KER_SIZE = 3,
    parameter int STRIDE   = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic [ADDR_W-1:0] imAddr,
    output logic [ADDR_W-1:0] kAddr,
    output logic [ADDR_W-1:0] filtimAddr,
    output logic              first_tap,
    output logic              last_tap,
    output logic              busy,
    output logic              done
);
    localparam int OUT_W = out_dim(IMG_W, KER_SIZE, STRIDE);
    localparam int OUT_H = out_dim(IMG_H, KER_SIZE, STRIDE);

    localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IMG_W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP_A = ADDR_W'(STRIDE * IMG_W);

    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("conv_addr_sequencer: IMG_W*IMG_H exceeds the ADDR_W address space");
    end
    if (KER_SIZE < 1 || KER_SIZE > IMG_W || KER_SIZE > IMG_H) begin : g_bad_ker
        $error("conv_addr_sequencer: KER_SIZE must lie in 1..min(IMG_W,IMG_H)");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $error("conv_addr_sequencer: STRIDE must be at least 1");
    end

    state_e state_q;
    logic   valid_q, busy_q, done_q, first_q;

    logic accept, run_clr;
    logic kx_last, ky_last, ox_last, oy_last;
    logic kx_wrap, ky_wrap, ox_wrap, oy_wrap;

    logic [ADDR_W-1:0] row_base_q, win_base_q, tap_row_q, im_q, k_q, filt_q;
    logic [ADDR_W-1:0] row_base_d, win_base_d, tap_row_d, im_d, k_d, filt_d;
    logic [ADDR_W-1:0] base_nxt;

    assign accept  = valid_q && ready;
    assign run_clr = (state_q != ST_RUN);

    conv_wrap_counter #(.LIMIT(KER_SIZE)) u_kx (
        .clk_i(clk), .rst_i(rst), .clr_i(run_clr), .en_i(accept),  .last_o(kx_last), .wrap_o(kx_wrap)
    );
    conv_wrap_counter #(.LIMIT(KER_SIZE)) u_ky (
        .clk_i(clk), .rst_i(rst), .clr_i(run_clr), .en_i(kx_wrap), .last_o(ky_last), .wrap_o(ky_wrap)
    );
    conv_wrap_counter #(.LIMIT(OUT_W)) u_ox (
        .clk_i(clk), .rst_i(rst), .clr_i(run_clr), .en_i(ky_wrap), .last_o(ox_last), .wrap_o(ox_wrap)
    );
    conv_wrap_counter #(.LIMIT(OUT_H)) u_oy (
        .clk_i(clk), .rst_i(rst), .clr_i(run_clr), .en_i(ox_wrap), .last_o(oy_last), .wrap_o(oy_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (oy_wrap) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        first_q <= 1'b0;
                    end else if (ky_wrap) begin
                        first_q <= 1'b1;
                    end else if (accept) begin
                        first_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    first_q <= 1'b0;
                end
            endcase
        end
    end

    // Address walk: tap -> kernel row -> window -> output row, each level rebased from the one above it.
    always_comb begin
        row_base_d = row_base_q;
        win_base_d = win_base_q;
        tap_row_d  = tap_row_q;
        im_d       = im_q;
        k_d        = k_q;
        filt_d     = filt_q;
        base_nxt   = '0;
        if (ky_wrap) begin
            k_d = '0;
            if (ox_last && oy_last) begin
                row_base_d = '0;
                win_base_d = '0;
                tap_row_d  = '0;
                im_d       = '0;
                filt_d     = '0;
            end else if (ox_last) begin
                base_nxt   = row_base_q + ROW_STEP_A;
                row_base_d = base_nxt;
                win_base_d = base_nxt;
                tap_row_d  = base_nxt;
                im_d       = base_nxt;
                filt_d     = filt_q + ONE_A;
            end else begin
                base_nxt   = win_base_q + STRIDE_A;
                win_base_d = base_nxt;
                tap_row_d  = base_nxt;
                im_d       = base_nxt;
                filt_d     = filt_q + ONE_A;
            end
        end else if (kx_wrap) begin
            base_nxt  = tap_row_q + IMG_W_A;
            tap_row_d = base_nxt;
            im_d      = base_nxt;
            k_d       = k_q + ONE_A;
        end else if (accept) begin
            im_d = im_q + ONE_A;
            k_d  = k_q + ONE_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q <= '0;
            win_base_q <= '0;
            tap_row_q  <= '0;
            im_q       <= '0;
            k_q        <= '0;
            filt_q     <= '0;
        end else begin
            row_base_q <= row_base_d;
            win_base_q <= win_base_d;
            tap_row_q  <= tap_row_d;
            im_q       <= im_d;
            k_q        <= k_d;
            filt_q     <= filt_d;
        end
    end

    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign imAddr     = im_q;
    assign kAddr      = k_q;
    assign filtimAddr = filt_q;
    assign first_tap  = first_q;
    assign last_tap   = valid_q && kx_last && ky_last;

endmodule
